mem_arbiter: RTL and testbench

Two-port arbiter that shares the CPU's single-port `memory` between the CPU datapath (instruction fetch, `LDW`, `STW`) and a debug/program-loader port. It sits between the requesters and the memory's `MemRead`/`MemWrite`/`ADDR`/data pins. It sequences each access through issue, latency wait and response. It also returns read data and a one-cycle acknowledge to whichever requester owns the access.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-pin bundle shared by mem_arbiter and its users
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;

    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] MemOut;

    logic          busy;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output MemRead, MemWrite, ADDR, DataIn,
        input  MemOut,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  MemRead, MemWrite, ADDR, DataIn,
        output MemOut,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug arbiter in front of a single-port memory (IDLE/ISSUE/WAIT/RESP)
// Define MEM_ARB_DBG_PRIORITY_EN for fixed debug priority; round-robin otherwise.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic         CLK,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant_dbg;

    // Contest resolution; an uncontested request simply wins.
    always_comb begin
        grant_dbg = 1'b0;
        if (bus.cpu_req && bus.dbg_req) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
            grant_dbg = 1'b1;
`else
            grant_dbg = !owner_q;
`endif
        end else begin
            grant_dbg = bus.dbg_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    owner_d = grant_dbg;
                    we_d    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
                    addr_d  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_d = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Writes leave both read-data registers untouched.
                    if (!we_q) begin
                        if (owner_q) begin
                            dbg_rdata_d = bus.MemOut;
                        end else begin
                            cpu_rdata_d = bus.MemOut;
                        end
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.MemRead   = (state_q == S_ISSUE) && !we_q;
    assign bus.MemWrite  = (state_q == S_ISSUE) && we_q;
    assign bus.ADDR      = addr_q;
    assign bus.DataIn    = wdata_q;
    assign bus.cpu_ack   = (state_q == S_RESP) && !owner_q;
    assign bus.dbg_ack   = (state_q == S_RESP) && owner_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (directed table, corner sequences, random vs model)
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N_RAND = 4000;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut  (.CLK(CLK), .reset(rst), .bus(bus));
    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (.CLK(CLK), .reset(rst), .bus(bus3));

    always #5 CLK = ~CLK;

    // Memory models: data is only presented on MemOut in the one cycle it is promised.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] mem3    [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic          pv  = 1'b0;
    logic [DW-1:0] pd  = '0;
    logic [2:0]    pv3 = '0;
    logic [DW-1:0] pd3 [0:2];

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 257) ^ 16'h3C3C;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = init_word(i);
            mem3[i] = init_word(i);
        end
        mem[5]  = 16'h1234;
        mem3[5] = 16'h1234;
        forever begin
            @(posedge CLK);
            pv     <= bus.MemRead;
            pd     <= mem[bus.ADDR[7:0]];
            pv3    <= {pv3[1:0], bus3.MemRead};
            pd3[0] <= mem3[bus3.ADDR[7:0]];
            pd3[1] <= pd3[0];
            pd3[2] <= pd3[1];
            if (bus.MemWrite)  mem[bus.ADDR[7:0]]   = bus.DataIn;
            if (bus3.MemWrite) mem3[bus3.ADDR[7:0]] = bus3.DataIn;
        end
    end

    assign bus.MemOut  = pv     ? pd     : 16'hDEAD;
    assign bus3.MemOut = pv3[2] ? pd3[2] : 16'hDEAD;

    typedef struct {
        logic          dbg;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_cpu;
        logic [DW-1:0] exp_dbg;
    } vec_t;

    vec_t vecs [8];

    int            g_cyc;
    int            ackc;
    logic          g_owner, g_we, exp_owner, win;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rd;
    logic [DW-1:0] exp_rd [2];
    int            p_state [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    int            n_ack, n_cpu, n_dbg;
    logic          who, exp_who;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (p == 0) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end else begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, " dbg_rdata"}, bus.dbg_rdata, 0);
        chk({tag, " cpu_ack"},   bus.cpu_ack,   0);
        chk({tag, " dbg_ack"},   bus.dbg_ack,   0);
        chk({tag, " MemRead"},   bus.MemRead,   0);
        chk({tag, " MemWrite"},  bus.MemWrite,  0);
        chk({tag, " ADDR"},      bus.ADDR,      0);
        chk({tag, " DataIn"},    bus.DataIn,    0);
        chk({tag, " busy"},      bus.busy,      0);
        chk({tag, " owner"},     bus.owner,     0);
    endtask

    task automatic clear_inputs();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.dbg_req = 1'b0; bus3.dbg_we = 1'b0; bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst = 1'b0;
    endtask

    // Single uncontested access on the MEM_LAT=1 instance; caller sits 1 time unit after an edge.
    task automatic run_vec(input vec_t v, input string tag);
        int p;
        p = v.dbg ? 1 : 0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            chk({tag, " MemRead"},  bus.MemRead,  (k == 1) && !v.we);
            chk({tag, " MemWrite"}, bus.MemWrite, (k == 1) && v.we);
            chk({tag, " busy"},     bus.busy,     (k >= 1) && (k <= 3));
            chk({tag, " cpu_ack"},  bus.cpu_ack,  (k == 3) && !v.dbg);
            chk({tag, " dbg_ack"},  bus.dbg_ack,  (k == 3) && v.dbg);
            if (k == 1) begin
                chk({tag, " ADDR"},  bus.ADDR,  v.addr);
                chk({tag, " owner"}, bus.owner, v.dbg);
                if (v.we) chk({tag, " DataIn"}, bus.DataIn, v.wdata);
            end
            if (k >= 3) begin
                chk({tag, " cpu_rdata"}, bus.cpu_rdata, v.exp_cpu);
                chk({tag, " dbg_rdata"}, bus.dbg_rdata, v.exp_dbg);
            end
            if (k == 0) drive(p, 1'b1, v.we, v.addr, v.wdata);
            if (k == 1) drive(p, 1'b1, !v.we, ~v.addr, ~v.wdata);
            if (k == 3) drive(p, 1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h0005, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'hAAAA, 16'hBEEF, 16'h1234};
        vecs[4] = '{1'b0, 1'b1, 16'h0020, 16'h5A5A, 16'hBEEF, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'hBEEF, 16'h5A5A};
        vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'h5A5A};

        clear_inputs();
        @(posedge CLK); #1;
        check_zero("reset");
        @(posedge CLK); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // MEM_LAT=3: address change during WAIT must not leak to the memory pins
        bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 16'h0005; bus3.cpu_wdata = '0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CLK); #1;
            chk("lat3 MemRead",  bus3.MemRead,  k == 1);
            chk("lat3 MemWrite", bus3.MemWrite, 0);
            chk("lat3 busy",     bus3.busy,     (k >= 1) && (k <= 5));
            chk("lat3 cpu_ack",  bus3.cpu_ack,  k == 5);
            chk("lat3 dbg_ack",  bus3.dbg_ack,  0);
            if (k <= 4) chk("lat3 ADDR", bus3.ADDR, 16'h0005);
            if (k == 2) bus3.cpu_addr = 16'h0007;
            if (k == 5) begin
                chk("lat3 cpu_rdata", bus3.cpu_rdata, 16'h1234);
                bus3.cpu_req = 1'b0;
            end
        end

        // Both requesters hammering from reset, four accesses each
        do_reset();
        drive(0, 1'b1, 1'b0, 16'h0005, '0);
        drive(1, 1'b1, 1'b0, 16'h0020, '0);
        n_ack = 0; n_cpu = 0; n_dbg = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            chk("contest dual ack", bus.cpu_ack & bus.dbg_ack, 0);
            if (bus.cpu_ack || bus.dbg_ack) begin
                who = bus.dbg_ack;
`ifdef MEM_ARB_DBG_PRIORITY_EN
                exp_who = (n_ack < 4);
`else
                exp_who = (n_ack % 2 == 0);
`endif
                if (n_ack < 8) begin
                    chk($sformatf("contest grant%0d port", n_ack), who, exp_who);
                    chk($sformatf("contest grant%0d cycle", n_ack), k, 3 + 4 * n_ack);
                end
                n_ack++;
                if (who) begin
                    n_dbg++;
                    if (n_dbg == 4) drive(1, 1'b0, 1'b0, '0, '0);
                end else begin
                    n_cpu++;
                    if (n_cpu == 4) drive(0, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        chk("contest ack count", n_ack, 8);

        // Reset in the middle of an access
        drive(0, 1'b1, 1'b0, 16'h0005, '0);
        @(posedge CLK); #1;
        chk("midrst MemRead", bus.MemRead, 1);
        @(posedge CLK); #1;
        chk("midrst busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge CLK); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("midrst no cpu_ack", bus.cpu_ack, 0);
            chk("midrst no dbg_ack", bus.dbg_ack, 0);
            chk("midrst idle", bus.busy, 0);
        end
        run_vec('{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 16'h0000}, "postrst");

        // Random traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        g_cyc = -1000; g_owner = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_rd = '0;
        exp_owner = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
        for (int p = 0; p < 2; p++) begin
            p_state[p] = 0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
        end
        for (int c = 0; c < N_RAND; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            ackc = g_cyc + 3;
            if (c == ackc && !g_we) exp_rd[g_owner] = g_rd;
            chk("rnd busy",     bus.busy,     (c > g_cyc) && (c <= ackc));
            chk("rnd MemRead",  bus.MemRead,  (c == g_cyc + 1) && !g_we);
            chk("rnd MemWrite", bus.MemWrite, (c == g_cyc + 1) && g_we);
            if (c > g_cyc && c < ackc) begin
                chk("rnd ADDR",   bus.ADDR,   g_addr);
                chk("rnd DataIn", bus.DataIn, g_wdata);
            end
            chk("rnd cpu_ack",   bus.cpu_ack,   (c == ackc) && !g_owner);
            chk("rnd dbg_ack",   bus.dbg_ack,   (c == ackc) && g_owner);
            chk("rnd owner",     bus.owner,     exp_owner);
            chk("rnd cpu_rdata", bus.cpu_rdata, exp_rd[0]);
            chk("rnd dbg_rdata", bus.dbg_rdata, exp_rd[1]);

            for (int p = 0; p < 2; p++) begin
                if (c == ackc && int'(g_owner) == p) begin
                    p_state[p] = 0;
                    drive(p, 1'b0, 1'(($urandom_range(0, 1))), 16'($urandom), 16'($urandom));
                end else if (p_state[p] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        p_state[p] = 1;
                        p_we[p]    = 1'($urandom_range(0, 1));
                        p_addr[p]  = 16'($urandom);
                        p_wdata[p] = 16'($urandom);
                        drive(p, 1'b1, p_we[p], p_addr[p], p_wdata[p]);
                    end else begin
                        drive(p, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
                    end
                end else if (p_state[p] == 2) begin
                    if ($urandom_range(0, 3) == 0)
                        drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              16'($urandom), 16'($urandom));
                end
            end

            if (c >= g_cyc + 4 && (p_state[0] == 1 || p_state[1] == 1)) begin
                if (p_state[0] == 1 && p_state[1] == 1) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
                    win = 1'b1;
`else
                    win = !exp_owner;
`endif
                end else begin
                    win = (p_state[1] == 1);
                end
                g_cyc   = c;
                g_owner = win;
                g_we    = p_we[win];
                g_addr  = p_addr[win];
                g_wdata = p_wdata[win];
                if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
                else      g_rd = ref_mem[g_addr[7:0]];
                p_state[win] = 2;
                exp_owner    = win;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
